// File: rtl/pkt_checksum_framer.sv
// Packet framer: groups the valid/ready word stream into PKT_LEN-word packets and appends a
// modular-sum checksum beat flagged by down_last. Define FRAMER_HDR_EN to prefix each packet with a sequence-number header.
module pkt_checksum_framer #(
  parameter int D_WIDTH = 6,
  parameter int PKT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready,
  output logic               down_last
);

  localparam int CNT_W = $clog2(PKT_LEN);

  typedef enum logic [1:0] {
    ST_HEADER,
    ST_PAYLOAD,
    ST_CHECKSUM
  } state_e;

`ifdef FRAMER_HDR_EN
  localparam state_e START_ST = ST_HEADER;
`else
  localparam state_e START_ST = ST_PAYLOAD;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [D_WIDTH-1:0] sum_q, sum_d;
  logic [D_WIDTH-1:0] data_q, data_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               out_free;
`ifdef FRAMER_HDR_EN
  logic [D_WIDTH-1:0] seq_q, seq_d;
`endif

  // The output register may reload in the same cycle it is drained, so full rate has no bubbles.
  assign out_free   = !valid_q || down_ready;
  assign up_ready   = rst && (state_q == ST_PAYLOAD) && out_free;
  assign down_data  = data_q;
  assign down_valid = valid_q;
  assign down_last  = last_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q && !down_ready;
`ifdef FRAMER_HDR_EN
    seq_d   = seq_q;
`endif
    case (state_q)
      ST_PAYLOAD: begin
        if (up_valid && up_ready) begin
          data_d  = up_data;
          last_d  = 1'b0;
          valid_d = 1'b1;
          sum_d   = sum_q + up_data;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PKT_LEN - 1)) state_d = ST_CHECKSUM;
        end
      end
      ST_CHECKSUM: begin
        if (out_free) begin
          data_d  = sum_q;
          last_d  = 1'b1;
          valid_d = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = START_ST;
        end
      end
`ifdef FRAMER_HDR_EN
      ST_HEADER: begin
        if (out_free) begin
          data_d  = seq_q;
          last_d  = 1'b0;
          valid_d = 1'b1;
          seq_d   = seq_q + D_WIDTH'(1);
          state_d = ST_PAYLOAD;
        end
      end
`endif
      default: state_d = START_ST;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an asynchronous reset; release is sampled on clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START_ST;
      cnt_q   <= '0;
      sum_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef FRAMER_HDR_EN
      seq_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
`ifdef FRAMER_HDR_EN
      seq_q   <= seq_d;
`endif
    end
  end

endmodule

// File: tb/tb_pkt_checksum_framer.sv
// Scoreboard bench for pkt_checksum_framer: the driver model pushes expected beats on each
// accepted word, the output monitor pops and compares on each downstream transfer.
module tb_pkt_checksum_framer;

  localparam int DW = 6;
  localparam int PL = 4;
`ifdef FRAMER_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BEAT_PER = PL + 1 + HDR;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] up_data = '0;
  logic          up_valid = 1'b0;
  logic          up_ready;
  logic [DW-1:0] down_data;
  logic          down_valid;
  logic          down_ready = 1'b1;
  logic          down_last;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] m_sum;
  int            m_cnt;
  logic [DW-1:0] m_seq;

  bit            rec_en = 0;
  int            rec_cyc[$];
  logic          rec_last[$];

  logic [DW:0]   mon_exp;
  bit            hold_chk = 0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  pkt_checksum_framer #(.D_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_last  (down_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: downstream transfers happen at the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (!rst) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        tests_run++;
        if (down_valid !== 1'b1 || down_data !== prev_d || down_last !== prev_l) begin
          tests_failed++;
          $display("FAIL hold_stable: got v=%0b d=%0d l=%0b, required v=1 d=%0d l=%0b",
                   down_valid, down_data, down_last, prev_d, prev_l);
        end
      end
      if (down_valid && down_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_beat: got d=%0d l=%0b, required no beat", down_data, down_last);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({down_last, down_data} !== mon_exp) begin
            tests_failed++;
            $display("FAIL beat: got d=%0d l=%0b, required d=%0d l=%0b",
                     down_data, down_last, mon_exp[DW-1:0], mon_exp[DW]);
          end
        end
        if (rec_en) begin
          rec_cyc.push_back(cyc);
          rec_last.push_back(down_last);
        end
      end
      hold_chk = down_valid && !down_ready;
      prev_d   = down_data;
      prev_l   = down_last;
    end
  end

  task automatic model_reset();
    exp_q.delete();
    m_sum = '0;
    m_cnt = 0;
    m_seq = '0;
    if (HDR != 0) begin
      exp_q.push_back({1'b0, m_seq});
      m_seq = m_seq + 1'b1;
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] w);
    exp_q.push_back({1'b0, w});
    m_sum = m_sum + w;
    m_cnt++;
    if (m_cnt == PL) begin
      exp_q.push_back({1'b1, m_sum});
      m_sum = '0;
      m_cnt = 0;
      if (HDR != 0) begin
        exp_q.push_back({1'b0, m_seq});
        m_seq = m_seq + 1'b1;
      end
    end
  endtask

  // Leaves up_valid high so consecutive calls stream at full rate; returns 1 ns after the accepting edge.
  task automatic send_word(input logic [DW-1:0] w);
    bit ok = 0;
    int n = 0;
    up_data  = w;
    up_valid = 1'b1;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (up_ready) ok = 1;
      n++;
    end
    if (!ok) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: got up_ready=0 for %0d cycles, required acceptance of %0d", n, w);
    end else begin
      model_accept(w);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    up_valid = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    up_valid = 1'b0;
    down_ready = 1'b1;
    #3;
    tests_run++;
    if ({down_valid, down_last, down_data, up_ready} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%0b l=%0b d=%0d up_ready=%0b, required all 0",
               down_valid, down_last, down_data, up_ready);
    end
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    drain();
  endtask

  task automatic test_basic();
    logic exp_rdy[3];
    exp_rdy[0] = 1'b0;
    exp_rdy[1] = (HDR != 0) ? 1'b0 : 1'b1;
    exp_rdy[2] = 1'b1;
    for (int i = 1; i <= 4; i++) send_word(DW'(i));
    up_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (up_ready !== exp_rdy[i]) begin
        tests_failed++;
        $display("FAIL up_ready_gap[%0d]: got %0b, required %0b", i, up_ready, exp_rdy[i]);
      end
    end
    drain();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) send_word(DW'(63));
    for (int i = 0; i < 3; i++) send_word(DW'(0));
    send_word(DW'(5));
    drain();
  endtask

  task automatic test_backpressure();
    fork
      begin
        send_word(DW'(7));
        send_word(DW'(8));
        send_word(DW'(9));
        send_word(DW'(10));
        up_valid = 1'b0;
      end
      begin
        int n = 0;
        bit seen = 0;
        while (!seen && n < 50) begin
          @(posedge clk);
          #1;
          if (down_valid && down_data == DW'(8)) seen = 1;
          n++;
        end
        if (seen) down_ready = 1'b0;
        tests_run++;
        if (!seen) begin
          tests_failed++;
          $display("FAIL stall_target: got no beat with data 8, required one");
        end
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          tests_run++;
          if (down_valid !== 1'b1 || down_data !== DW'(8)) begin
            tests_failed++;
            $display("FAIL stall_hold[%0d]: got v=%0b d=%0d, required v=1 d=8", i, down_valid, down_data);
          end
        end
        @(posedge clk);
        #1;
        down_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_mid_packet();
    send_word(DW'(5));
    send_word(DW'(6));
    up_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if ({down_valid, down_last, down_data, up_ready} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%0b l=%0b d=%0d up_ready=%0b, required all 0",
               down_valid, down_last, down_data, up_ready);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) send_word(DW'(1));
    drain();
  endtask

  task automatic test_back_to_back();
    int total;
    rec_cyc.delete();
    rec_last.delete();
    rec_en = 1;
    for (int i = 0; i < 3 * PL; i++) send_word(DW'($urandom_range(0, 63)));
    drain();
    rec_en = 0;
    total = 3 * BEAT_PER;
    tests_run++;
    if (rec_cyc.size() != total) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d beats, required %0d", rec_cyc.size(), total);
    end else begin
      tests_run++;
      if (rec_cyc[total-1] - rec_cyc[0] != total - 1) begin
        tests_failed++;
        $display("FAIL b2b_span: got %0d cycles, required %0d", rec_cyc[total-1] - rec_cyc[0] + 1, total);
      end
      for (int i = 0; i < total; i++) begin
        logic exp_last;
        exp_last = ((i + 1 + HDR) % BEAT_PER) == 0;
        tests_run++;
        if (rec_last[i] !== exp_last) begin
          tests_failed++;
          $display("FAIL b2b_last[%0d]: got %0b, required %0b", i + 1, rec_last[i], exp_last);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_reset_mid_packet();
    test_back_to_back();
    test_basic();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
